// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the AXI4 instruction fetch unit.
//
// Contents:
//   fetch_state_e  - fetch FSM states (IDLE, ADDR, DATA, DRAIN)
//   AXI_*          - fixed AXI4 encodings used by the read master
//   PAGE_BYTES     - bursts never cross this boundary
//   burst_arlen()  - ARLEN for a burst starting at a given page offset
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StDrain
    } fetch_state_e;

    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam int unsigned PAGE_BYTES     = 4096;

    // min(max_beats, words left before the next page boundary) - 1
    function automatic logic [7:0] burst_arlen(input logic [11:0] page_off,
                                               input int unsigned max_beats);
        int unsigned words_left;
        int unsigned beats;
        words_left = (PAGE_BYTES - 32'(page_off)) >> 2;
        beats      = (words_left < max_beats) ? words_left : max_beats;
        return 8'(beats - 1);
    endfunction

endpackage

// File: rtl/inst_fetch_axi_fifo.sv
// inst_fifo: synchronous show-ahead FIFO for fetched {instruction, PC} entries.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - empties the FIFO; wins over push and pop in the same cycle
//   push, wdata - write an entry
//   pop         - consume the head entry (ignored when empty)
//   rdata       - head entry, valid whenever empty is low
//   empty       - no entries held
//   count       - number of entries held
module inst_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      count_q;
    logic             full;
    logic             push_ok, pop_ok;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rptr_q];

    // A push into a full FIFO is fine when the head leaves in the same cycle.
    always_comb begin
        push_ok = push && (!full || pop);
        pop_ok  = pop && !empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/inst_fetch_axi.sv
// inst_fetch_axi: AXI4 read-only instruction fetch unit.
//
// Issues INCR bursts from a sequential fetch PC (never crossing a 4 KB page),
// buffers returned words with their PCs, and hands them to decode over
// valid/ready. A redirect flushes the buffer and drains any in-flight burst.
// Buffer space is reserved at address issue, so RREADY never waits on decode.
//
// Ports:
//   ACLK, ARESETN          - clock, asynchronous active-low reset
//   EN                     - allow new bursts
//   REDIR_VALID, REDIR_PC  - single-cycle redirect to a word-aligned target
//   INST_VALID/READY       - decode handshake; INST_DATA / INST_PC are the head entry
//   M_INST_AXI_AR*         - read address channel (ARID/ARSIZE/ARBURST constant)
//   M_INST_AXI_R*          - read data channel
//   BUSY                   - a burst is being requested or is outstanding
//   ERR, ERR_PC            - only with INST_FETCH_ERRCHK_EN: sticky bus error and
//                            the PC of the first failing beat
//
// Build option INST_FETCH_ERRCHK_EN: when defined, a non-OKAY beat stops delivery
// and fetch until reset or redirect. When undefined, RRESP is ignored.
module inst_fetch_axi
    import inst_fetch_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH      = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH      = 32,
    parameter int unsigned C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int unsigned BURST_LEN               = 8,
    parameter int unsigned FIFO_DEPTH              = 16,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    input  logic                               EN,
    input  logic                               REDIR_VALID,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]      REDIR_PC,
    output logic                               INST_VALID,
    input  logic                               INST_READY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]      INST_DATA,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      INST_PC,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_INST_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_INST_AXI_ARADDR,
    output logic [7:0]                         M_INST_AXI_ARLEN,
    output logic [2:0]                         M_INST_AXI_ARSIZE,
    output logic [1:0]                         M_INST_AXI_ARBURST,
    output logic                               M_INST_AXI_ARVALID,
    input  logic                               M_INST_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_INST_AXI_RDATA,
    input  logic [1:0]                         M_INST_AXI_RRESP,
    input  logic                               M_INST_AXI_RLAST,
    input  logic                               M_INST_AXI_RVALID,
    output logic                               M_INST_AXI_RREADY,
`ifdef INST_FETCH_ERRCHK_EN
    output logic                               ERR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      ERR_PC,
`endif
    output logic                               BUSY
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned FW = DW + AW;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic [7:0]    arlen_q, arlen_d;
    logic [CW-1:0] reserved_q, reserved_d;
    logic          drain_pend_q, drain_pend_d;

    logic          ar_hs, r_hs, push, can_issue;
    logic          beat_bad, fetch_blocked;
    logic [FW-1:0] fifo_rdata;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign ar_hs = M_INST_AXI_ARVALID && M_INST_AXI_ARREADY;
    assign r_hs  = M_INST_AXI_RVALID && M_INST_AXI_RREADY;

    // Room for a full burst after counting buffered and already-promised beats.
    assign can_issue = (32'(fifo_count) + 32'(reserved_q) + BURST_LEN) <= FIFO_DEPTH;

    // Beats of a burst issued before a redirect are consumed but never pushed.
    assign push = (state_q == StData) && r_hs && !REDIR_VALID && !fetch_blocked && !beat_bad;

`ifdef INST_FETCH_ERRCHK_EN
    logic          err_q, err_d;
    logic [AW-1:0] err_pc_q, err_pc_d;

    assign beat_bad      = (M_INST_AXI_RRESP != AXI_RESP_OKAY);
    assign fetch_blocked = err_q;

    always_comb begin
        err_d    = err_q;
        err_pc_d = err_pc_q;
        if (REDIR_VALID) begin
            err_d = 1'b0;
        end else if ((state_q == StData) && r_hs && beat_bad && !err_q) begin
            err_d    = 1'b1;
            err_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_q    <= 1'b0;
            err_pc_q <= '0;
        end else begin
            err_q    <= err_d;
            err_pc_q <= err_pc_d;
        end
    end

    assign ERR    = err_q;
    assign ERR_PC = err_pc_q;
`else
    logic unused_rresp;
    assign unused_rresp  = ^M_INST_AXI_RRESP;
    assign beat_bad      = 1'b0;
    assign fetch_blocked = 1'b0;
`endif

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (EN && !REDIR_VALID && can_issue && !fetch_blocked) state_d = StAddr;
            end
            StAddr: begin
                // The address must complete even after a redirect; its data is then dropped.
                if (M_INST_AXI_ARREADY) begin
                    state_d = (drain_pend_q || REDIR_VALID) ? StDrain : StData;
                end
            end
            StData: begin
                if (r_hs && M_INST_AXI_RLAST) state_d = StIdle;
                else if (REDIR_VALID)         state_d = StDrain;
            end
            StDrain: begin
                if (r_hs && M_INST_AXI_RLAST) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        M_INST_AXI_ARVALID = (state_q == StAddr);
        M_INST_AXI_RREADY  = (state_q == StData) || (state_q == StDrain);
        BUSY               = (state_q != StIdle);
    end

    // Datapath next-state
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        reserved_d   = reserved_q;
        drain_pend_d = 1'b0;

        if (REDIR_VALID) begin
            fetch_pc_d = REDIR_PC;
        end else if ((state_q == StData) && r_hs) begin
            fetch_pc_d = fetch_pc_q + AW'(4);
        end

        // Address and length are frozen for the whole ARVALID period.
        if ((state_q == StIdle) && (state_d == StAddr)) begin
            araddr_d = fetch_pc_q;
            arlen_d  = burst_arlen(fetch_pc_q[11:0], BURST_LEN);
        end

        if (ar_hs) begin
            reserved_d = reserved_q + CW'(32'(arlen_q) + 32'd1);
        end else if (r_hs) begin
            reserved_d = reserved_q - CW'(1);
        end

        if ((state_q == StAddr) && !M_INST_AXI_ARREADY) begin
            drain_pend_d = drain_pend_q || REDIR_VALID;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            fetch_pc_q   <= RESET_PC;
            araddr_q     <= '0;
            arlen_q      <= '0;
            reserved_q   <= '0;
            drain_pend_q <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            reserved_q   <= reserved_d;
            drain_pend_q <= drain_pend_d;
        end
    end

    assign M_INST_AXI_ARID    = '0;
    assign M_INST_AXI_ARADDR  = araddr_q;
    assign M_INST_AXI_ARLEN   = arlen_q;
    assign M_INST_AXI_ARSIZE  = AXI_SIZE_4B;
    assign M_INST_AXI_ARBURST = AXI_BURST_INCR;

    inst_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .flush (REDIR_VALID),
        .push  (push),
        .wdata ({M_INST_AXI_RDATA, fetch_pc_q}),
        .pop   (INST_READY),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign INST_VALID = !fifo_empty;
    assign INST_DATA  = fifo_rdata[FW-1 -: DW];
    assign INST_PC    = fifo_rdata[AW-1:0];

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Self-checking bench for inst_fetch_axi: directed scenarios plus a randomized
// run, checked against a transaction-level model of the fetch stream.
module tb_inst_fetch_axi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, redir_valid, inst_valid, inst_ready;
    logic [31:0] redir_pc, inst_data, inst_pc;
    logic [0:0]  arid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready, busy;
`ifdef INST_FETCH_ERRCHK_EN
    logic        err;
    logic [31:0] err_pc;
`endif

    always #5 clk = ~clk;

    inst_fetch_axi #(
        .C_M_AXI_ADDR_WIDTH      (32),
        .C_M_AXI_DATA_WIDTH      (32),
        .C_M_AXI_THREAD_ID_WIDTH (1),
        .BURST_LEN               (8),
        .FIFO_DEPTH              (16),
        .RESET_PC                (32'h100)
    ) dut (
        .ACLK               (clk),
        .ARESETN            (rst_n),
        .EN                 (en),
        .REDIR_VALID        (redir_valid),
        .REDIR_PC           (redir_pc),
        .INST_VALID         (inst_valid),
        .INST_READY         (inst_ready),
        .INST_DATA          (inst_data),
        .INST_PC            (inst_pc),
        .M_INST_AXI_ARID    (arid),
        .M_INST_AXI_ARADDR  (araddr),
        .M_INST_AXI_ARLEN   (arlen),
        .M_INST_AXI_ARSIZE  (arsize),
        .M_INST_AXI_ARBURST (arburst),
        .M_INST_AXI_ARVALID (arvalid),
        .M_INST_AXI_ARREADY (arready),
        .M_INST_AXI_RDATA   (rdata),
        .M_INST_AXI_RRESP   (rresp),
        .M_INST_AXI_RLAST   (rlast),
        .M_INST_AXI_RVALID  (rvalid),
        .M_INST_AXI_RREADY  (rready),
`ifdef INST_FETCH_ERRCHK_EN
        .ERR                (err),
        .ERR_PC             (err_pc),
`endif
        .BUSY               (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0000;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(1) == 1) t = (t & ~32'hFFF) | (32'hFFC - 32'(4 * $urandom_range(9)));
        return t;
    endfunction

    // Reference model: expected stream, buffer occupancy, promised beats, next burst address
    logic [31:0] exp_pc = 32'h100;
    logic [31:0] next_ar = 32'h100;
    int          fifo_n = 0, reserved_n = 0;
    bit          tainted = 0, err_m = 0;
    logic [31:0] err_pc_m = '0;

    // Slave state
    bit          s_active = 0;
    logic [31:0] s_addr;
    int          s_left = 0, s_beat_idx = 0, s_delay = 0;

    // AR monitor
    bit          prev_arvalid = 0;
    logic [31:0] held_addr;
    logic [7:0]  held_len;
    int          stall_left = 0;
    logic [31:0] ar_log_addr[$];
    logic [7:0]  ar_log_len[$];
    int          ar_count = 0, n_pops = 0, pop_budget = 1 << 30;

    // Stimulus knobs
    bit          k_en = 0, k_rand_redir = 0, k_rand_en = 0;
    int          k_arready_pct = 100, k_rvalid_pct = 100, k_ready_pct = 100, k_delay_max = 0;
    int          k_ar_stall = 0;
    bit          k_redir_in_stall = 0, k_beat_redir = 0, k_force_redir = 0, k_err_en = 0;
    logic [31:0] k_force_tgt, k_stall_tgt, k_beat_tgt, k_err_addr = '0;

    task automatic step();
        logic        ar_hs, r_hs, pop, redir, rv;
        logic [31:0] tgt;
        int unsigned words;
        @(negedge clk);
        check_eq("inst_valid", inst_valid, fifo_n != 0);
        check_eq("busy", busy, arvalid || s_active);
        check_eq("rready", rready, s_active);
`ifdef INST_FETCH_ERRCHK_EN
        check_eq("err", err, err_m);
        if (err_m) check_eq("err_pc", err_pc, err_pc_m);
`endif
        if (arvalid && !prev_arvalid) begin
            words = (4096 - 32'(next_ar[11:0])) / 4;
            check_eq("araddr", araddr, next_ar);
            check_eq("arlen", arlen, (words < 8) ? words - 1 : 7);
            check_eq("ar_room", (fifo_n + reserved_n + 8 <= 16) && !err_m && !s_active, 1);
            check_eq("ar_fixed", {arid, arsize, arburst}, {1'b0, 3'b010, 2'b01});
            ar_log_addr.push_back(araddr);
            ar_log_len.push_back(arlen);
            held_addr  = araddr;
            held_len   = arlen;
            stall_left = k_ar_stall;
            k_ar_stall = 0;
            if (k_redir_in_stall) begin
                k_force_redir    = 1;
                k_force_tgt      = k_stall_tgt;
                k_redir_in_stall = 0;
            end
        end else if (arvalid) begin
            check_eq("araddr_hold", araddr, held_addr);
            check_eq("arlen_hold", arlen, held_len);
        end

        if (stall_left > 0) begin
            arready = 0;
            stall_left--;
        end else begin
            arready = ($urandom_range(99) < k_arready_pct);
        end
        rv = 0;
        if (s_active) begin
            if (s_delay > 0) s_delay--;
            else rv = ($urandom_range(99) < k_rvalid_pct);
        end
        rvalid = rv;
        rdata  = rv ? mem_word(s_addr) : $urandom;
        rlast  = rv && (s_left == 1);
        rresp  = (rv && k_err_en && s_addr == k_err_addr) ? 2'b10 : 2'b00;
        inst_ready = ($urandom_range(99) < k_ready_pct) && (pop_budget > 0);
        if (k_rand_en && $urandom_range(99) == 0) k_en = !k_en;
        en = k_en;

        redir = 0;
        tgt   = '0;
        if (k_force_redir) begin
            redir = 1;
            tgt   = k_force_tgt;
            k_force_redir = 0;
        end else if (k_beat_redir && rv && s_beat_idx == 2) begin
            redir = 1;
            tgt   = k_beat_tgt;
            k_beat_redir = 0;
        end else if (k_rand_redir && $urandom_range(63) == 0) begin
            redir = 1;
            tgt   = rand_target();
        end
        redir_valid = redir;
        redir_pc    = tgt;

        ar_hs = arvalid && arready;
        r_hs  = rv && s_active;
        pop   = inst_valid && inst_ready && !redir;

        if (pop) begin
            check_eq("inst_pc", inst_pc, exp_pc);
            check_eq("inst_data", inst_data, mem_word(exp_pc));
            exp_pc += 4;
            fifo_n--;
            n_pops++;
            pop_budget--;
        end
        if (r_hs) begin
            if (!tainted && !redir && !err_m) begin
                if (rresp != 2'b00) begin
                    err_m    = 1;
                    err_pc_m = s_addr;
                end else begin
                    fifo_n++;
                end
            end
            if (!tainted) next_ar = s_addr + 4;
            reserved_n--;
            s_addr += 4;
            s_left--;
            s_beat_idx++;
            if (s_left == 0) begin
                s_active = 0;
                tainted  = 0;
            end
        end
        if (ar_hs) begin
            s_active   = 1;
            s_addr     = araddr;
            s_left     = int'(arlen) + 1;
            s_beat_idx = 0;
            s_delay    = (k_delay_max == 0) ? 0 : $urandom_range(k_delay_max);
            reserved_n += int'(arlen) + 1;
            ar_count++;
        end
        if (redir) begin
            fifo_n  = 0;
            exp_pc  = tgt;
            next_ar = tgt;
            err_m   = 0;
            if (arvalid || s_active) tainted = 1;
        end
        prev_arvalid = arvalid;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic go_idle();
        k_en = 0;
        k_rand_en = 0;
        k_rand_redir = 0;
        k_ready_pct = 100;
        k_arready_pct = 100;
        k_rvalid_pct = 100;
        k_delay_max = 0;
        pop_budget = 1 << 30;
        for (int i = 0; i < 300; i++) begin
            step();
            if (!busy && !inst_valid) break;
        end
        check_eq("idle_reached", {busy, inst_valid}, 2'b00);
    endtask

    task automatic wait_ars(input int n, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (ar_log_addr.size() >= n) break;
            step();
        end
        check_eq(tag, ar_log_addr.size() >= n, 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int a0, p0;
        rst_n = 0;
        en = 0; redir_valid = 0; redir_pc = '0; inst_ready = 0;
        arready = 0; rvalid = 0; rdata = '0; rlast = 0; rresp = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_rready", rready, 0);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_busy", busy, 0);
        rst_n = 1;

        // 1: basic fetch from RESET_PC
        k_en = 1;
        for (int i = 0; i < 100 && n_pops < 8; i++) step();
        check_eq("t1_pops", n_pops >= 8, 1);
        check_eq("t1_araddr", ar_log_addr[0], 32'h100);
        check_eq("t1_arlen", ar_log_len[0], 7);

        // 2: decode stalled, reservation limits to two bursts
        go_idle();
        k_force_redir = 1; k_force_tgt = 32'h3000;
        k_ready_pct = 0; k_en = 1;
        a0 = ar_count;
        run(150);
        check_eq("t2_bursts", ar_count - a0, 2);
        check_eq("t2_no_arvalid", arvalid, 0);
        pop_budget = 7; k_ready_pct = 100;
        run(40);
        check_eq("t2_after7_bursts", ar_count - a0, 2);
        check_eq("t2_after7_arvalid", arvalid, 0);
        pop_budget = 1;
        for (int i = 0; i < 40 && ar_count - a0 < 3; i++) step();
        check_eq("t2_third_burst", ar_count - a0, 3);

        // 3: redirect on the third beat
        go_idle();
        ar_log_addr.delete(); ar_log_len.delete();
        k_force_redir = 1; k_force_tgt = 32'h1800;
        k_beat_redir = 1; k_beat_tgt = 32'h2000; k_en = 1;
        wait_ars(2, "t3_two_bursts");
        check_eq("t3_ar0", ar_log_addr[0], 32'h1800);
        check_eq("t3_ar1", ar_log_addr[1], 32'h2000);
        run(20);

        // 4: 4 KB clipping
        go_idle();
        ar_log_addr.delete(); ar_log_len.delete();
        k_force_redir = 1; k_force_tgt = 32'hFF8; k_en = 1;
        wait_ars(2, "t4_two_bursts");
        check_eq("t4_ar0", ar_log_addr[0], 32'hFF8);
        check_eq("t4_len0", ar_log_len[0], 1);
        check_eq("t4_ar1", ar_log_addr[1], 32'h1000);
        check_eq("t4_len1", ar_log_len[1], 7);

        // 5: redirect while the address is stalled
        go_idle();
        ar_log_addr.delete(); ar_log_len.delete();
        k_force_redir = 1; k_force_tgt = 32'h700;
        k_ar_stall = 3; k_redir_in_stall = 1; k_stall_tgt = 32'h5000; k_en = 1;
        wait_ars(2, "t5_two_bursts");
        check_eq("t5_ar0", ar_log_addr[0], 32'h700);
        check_eq("t5_ar1", ar_log_addr[1], 32'h5000);
        run(20);

        // Randomized traffic
        go_idle();
        k_arready_pct = 60; k_rvalid_pct = 70; k_ready_pct = 60; k_delay_max = 3;
        k_rand_redir = 1; k_rand_en = 1; k_en = 1;
        run(4000);
        go_idle();

`ifdef INST_FETCH_ERRCHK_EN
        // 6: bus error on beat 4 of the burst at 0x400
        k_force_redir = 1; k_force_tgt = 32'h400;
        k_err_en = 1; k_err_addr = 32'h40C; k_en = 1;
        p0 = n_pops; a0 = ar_count;
        run(60);
        check_eq("t6_err", err, 1);
        check_eq("t6_err_pc", err_pc, 32'h40C);
        check_eq("t6_pops", n_pops - p0, 3);
        check_eq("t6_bursts", ar_count - a0, 1);
        check_eq("t6_no_arvalid", arvalid, 0);
        k_en = 0; k_err_en = 0;
        k_force_redir = 1; k_force_tgt = 32'h800;
        run(2);
        check_eq("t6_err_cleared", err, 0);
`else
        p0 = n_pops;
        a0 = ar_count;
        check_eq("final_inst_valid", inst_valid, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_axi.md
Name: inst_fetch_axi

Overview:
- Parametrised AXI4 read-only instruction fetch unit; successor to the core's tied-off instruction master.
- Issues INCR read bursts from a sequential fetch PC and buffers returned words in an internal FIFO.
- Presents words to the decode stage over a valid/ready interface, each tagged with its PC.
- Supports a redirect (branch/jump) that flushes buffered and in-flight instructions.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address / PC width
- C_M_AXI_DATA_WIDTH, 32, data width; fixed at 32 (one instruction per beat)
- C_M_AXI_THREAD_ID_WIDTH, 1, ARID/RID width
- BURST_LEN, 8, maximum beats per burst (1..16)
- FIFO_DEPTH, 16, instruction buffer entries; power of two, >= BURST_LEN
- RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- EN  in  1  fetch enable; new bursts are issued only while high
- REDIR_VALID  in  1  redirect strobe (single cycle)
- REDIR_PC  in  ADDR  redirect target, word aligned
- INST_VALID  out  1  instruction available
- INST_READY  in  1  decode accepts the instruction
- INST_DATA  out  32  instruction word
- INST_PC  out  ADDR  PC of INST_DATA
- M_INST_AXI_ARID  out  ID  constant 0
- M_INST_AXI_ARADDR  out  ADDR  burst start address
- M_INST_AXI_ARLEN  out  8  beats-1
- M_INST_AXI_ARSIZE  out  3  3'b010
- M_INST_AXI_ARBURST  out  2  2'b01 (INCR)
- M_INST_AXI_ARVALID  out  1  address valid
- M_INST_AXI_ARREADY  in  1  address ready
- M_INST_AXI_RDATA  in  32  read data
- M_INST_AXI_RRESP  in  2  read response
- M_INST_AXI_RLAST  in  1  last beat
- M_INST_AXI_RVALID  in  1  data valid
- M_INST_AXI_RREADY  out  1  data ready
- BUSY  out  1  burst outstanding (state != IDLE)

Behaviour:
Reset (async assert, sync deassert):
- ARVALID=0, RREADY=0, INST_VALID=0, BUSY=0.
- FIFO empty; fetch_pc=RESET_PC; reserved=0.

States:
- IDLE -> ADDR when EN=1, no pending redirect, and free slots (FIFO_DEPTH - count - reserved) >= BURST_LEN.
- ADDR: ARVALID=1.
  - ARADDR = fetch_pc.
  - ARLEN = min(BURST_LEN, words remaining to the next 4 KB boundary) - 1.
  - ARADDR/ARLEN are held stable until ARREADY. On the handshake: reserved += ARLEN+1, then go to DATA.
- DATA: RREADY=1. On each RVALID&RREADY:
  - Push {RDATA, beat PC}; reserved -= 1; fetch_pc += 4.
  - On RLAST go to IDLE.
- DRAIN: RREADY=1. Beats are discarded; reserved is decremented per beat. On RLAST go to IDLE.

Redirect (highest priority, any state):
- FIFO is flushed the same cycle, INST_VALID=0 next cycle, and fetch_pc=REDIR_PC.
- ADDR: ARVALID stays high until ARREADY (AXI rule), then go to DRAIN.
- DATA: go to DRAIN; the beat accepted in the redirect cycle is discarded.
- IDLE/DRAIN: only fetch_pc is updated.
- A redirect coinciding with a pop: the pop is dropped and the FIFO is flushed.

FIFO and flow rules:
- Zero-latency show-ahead: INST_DATA/INST_PC are valid whenever INST_VALID=1.
- Simultaneous push and pop is legal at any occupancy. Reservation makes overflow impossible, so RREADY never depends on INST_READY.
- At most one burst outstanding. Latency from ARREADY to first push is the slave latency; no added cycles.
- EN low finishes the current burst and issues no new one.
- PC arithmetic is modulo 2^ADDR; 4 KB clipping prevents wrap within a burst.

Optional Feature:
- Macro INST_FETCH_ERRCHK_EN.
- Defined:
  - Adds output ERR (1) and ERR_PC (ADDR).
  - The first beat with RRESP != 2'b00 sets ERR and captures its PC.
  - That beat and later beats are not pushed, and no further bursts issue.
  - Cleared only by reset or redirect.
- Undefined: RRESP is ignored and all beats are pushed.

Decomposition:
- Package inst_fetch_pkg holds:
  - State enum: IDLE, ADDR, DATA, DRAIN.
  - Constants AXI_SIZE_4B=3'b010, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, PAGE_BYTES=4096.
- Sub-module inst_fifo: synchronous FIFO (width 32+ADDR, depth FIFO_DEPTH) with flush, count, and show-ahead output.

Test Plan:
1. Reset, then EN=1, RESET_PC=0x100, slave ARREADY=1, 1-cycle latency -> ARADDR=0x100, ARLEN=7; INST_PC 0x100..0x11C in order with the correct data.
2. INST_READY=0 held, FIFO_DEPTH=16, BURST_LEN=8 -> exactly two bursts; third ARVALID not asserted until at least 8 pops.
3. Redirect to 0x2000 on the 3rd beat of a burst -> FIFO empty next cycle; remaining 5 beats accepted and dropped; next ARADDR=0x2000; first INST_PC=0x2000.
4. fetch_pc=0xFF8 -> ARLEN=1 (2 beats), next ARADDR=0x1000 with ARLEN=7.
5. Redirect while ARVALID=1 and ARREADY=0 for 3 cycles -> ARADDR/ARLEN stable until handshake; burst drained; then new address issued.
6. (INST_FETCH_ERRCHK_EN) RRESP=2'b10 on beat 4 of burst at 0x400 -> ERR=1, ERR_PC=0x40C; only 3 instructions delivered; no new ARVALID; redirect clears ERR.
